// File: rtl/edge_map_packer.sv
// edge_map_packer: packs a 1-bit-per-pixel edge stream into bytes and writes them to a frame memory
//    clk        system clock, all logic on posedge
//    rst        asynchronous active-low reset
//    pix_in     edge pixel, edge bit is pix_in[23]
//    pix_valid  pixel valid (no backpressure)
//    sof        start of frame, qualifies pixel (0,0)
//    wr_en/wr_addr/wr_data/wr_ready  byte write port, popped on wr_en&&wr_ready
//    busy       high in RUN and DRAIN
//    frame_done one-cycle pulse after the last byte of a frame is written
//    overflow   sticky, a byte was dropped because the FIFO was full
//    Macro PACK_MSB_FIRST_EN: column 8k+i lands in wr_data[7-i] instead of wr_data[i]
module edge_map_packer #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [23:0]       pix_in,
   input  logic              pix_valid,
   input  logic              sof,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
);
   localparam int CW = $clog2(H_RES + 8);
   localparam int RW = $clog2(V_RES + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic [ADDR_W-1:0] addr, cur_addr, a1;
   logic [7:0] sr, byte_nx, d1;
   logic [2:0] pos;
   logic [1:0] cnt, occ;
   logic start, acc, line_end, byte_end, last, pop, push;
   // A sof pixel overrides the running counters so it is always (0,0), address 0, empty byte.
   always_comb begin
      start    = pix_valid && sof && (state == IDLE || state == RUN);
      acc      = start || (pix_valid && state == RUN);
      cur_col  = start ? '0 : col;
      cur_row  = start ? '0 : row;
      cur_addr = start ? '0 : addr;
`ifdef PACK_MSB_FIRST_EN
      pos      = 3'd7 - cur_col[2:0];
`else
      pos      = cur_col[2:0];
`endif
      byte_nx  = (start ? 8'h00 : sr) | ({7'b0, pix_in[23]} << pos);
      line_end = cur_col == COL_LAST;
      byte_end = acc && (cur_col[2:0] == 3'd7 || line_end);
      last     = acc && line_end && cur_row == ROW_LAST;
      wr_en    = cnt != 2'd0;
      pop      = wr_en && wr_ready;
      occ      = cnt - {1'b0, pop};
      push     = byte_end && occ != 2'd2;
      busy       = state == RUN || state == DRAIN;
      frame_done = state == DONE;
      state_nx = state;
      case (state)
         IDLE:  state_nx = start ? (last ? DRAIN : RUN) : IDLE;
         RUN:   state_nx = last ? DRAIN : RUN;
         DRAIN: state_nx = (occ == 2'd0) ? DONE : DRAIN;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         sr       <= '0;
         addr     <= '0;
         cnt      <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         a1       <= '0;
         d1       <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (acc) begin
            col  <= line_end ? '0 : cur_col + 1'b1;
            row  <= line_end ? cur_row + 1'b1 : cur_row;
            sr   <= byte_end ? 8'h00 : byte_nx;
            // a dropped byte still consumes its address
            addr <= byte_end ? cur_addr + 1'b1 : cur_addr;
         end
         overflow <= (byte_end && !push) || (overflow && !(start && state == IDLE));
         if (pop) begin
            wr_data <= d1;
            wr_addr <= a1;
         end
         if (push && occ == 2'd0) begin
            wr_data <= byte_nx;
            wr_addr <= cur_addr;
         end
         if (push && occ == 2'd1) begin
            d1 <= byte_nx;
            a1 <= cur_addr;
         end
         cnt <= occ + {1'b0, push};
      end
   end
endmodule
